vga_timing_gen: RTL

//  VGA raster timing generator, the producer side of the h_cnt/v_cnt interface consumed by the pixel generator.

---
 rtl/vga_timing_gen_pkg.sv | 37 +++
 rtl/vga_sync_delay.sv | 28 ++
 rtl/vga_timing_gen.sv | 116 +++++++++++
 3 files changed

// File: rtl/vga_timing_gen_pkg.sv
// Shared timing constants, coordinate type and pipeline stage layout for the VGA raster generator.
// The H_/V_ values are the 640x480@60 defaults that the top-level parameters start from.
package vga_timing_pkg;

  typedef logic [9:0] coord_t;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  // One pixel's worth of output data as it travels down the delay line.
  typedef struct packed {
    logic        valid;
    logic        hs;
    logic        vs;
    logic [11:0] rgb;
  } pix_stage_t;

  // Half-open window test, lo <= pos < hi, done in 10 bits.
  function automatic logic in_window(coord_t pos, coord_t lo, coord_t hi);
    return (pos >= lo) && (pos < hi);
  endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// DEPTH-stage shift register carrying {valid, hs, vs, rgb}; every stage moves only on a pixel tick,
// so the lag is counted in pixel periods, not system clocks.
module vga_sync_delay
  import vga_timing_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_i,
  input  pix_stage_t d_i,
  output pix_stage_t q_o
);

  pix_stage_t stage_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else if (en_i) begin
      stage_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-tick divider, h/v counters, active decode, frame_start,
// and the pixel-tick-aligned delay line that lines RGB up with hsync/vsync.
module vga_timing_gen #(
  parameter int   CLK_DIV  = 4,
  parameter int   H_ACTIVE = vga_timing_pkg::H_ACTIVE,
  parameter int   H_FP     = vga_timing_pkg::H_FP,
  parameter int   H_SYNC   = vga_timing_pkg::H_SYNC,
  parameter int   H_BP     = vga_timing_pkg::H_BP,
  parameter int   V_ACTIVE = vga_timing_pkg::V_ACTIVE,
  parameter int   V_FP     = vga_timing_pkg::V_FP,
  parameter int   V_SYNC   = vga_timing_pkg::V_SYNC,
  parameter int   V_BP     = vga_timing_pkg::V_BP,
  parameter logic SYNC_POL = 1'b0,
  parameter int   PIPE_DLY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] pixel_in,
  output logic        pix_tick,
  output logic [9:0]  h_cnt,
  output logic [9:0]  v_cnt,
  output logic        valid,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_start
);

  localparam int H_TOT  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_BEG = H_ACTIVE + H_FP;
  localparam int VS_BEG = V_ACTIVE + V_FP;
  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  import vga_timing_pkg::*;

  localparam coord_t H_LAST  = coord_t'(H_TOT - 1);
  localparam coord_t V_LAST  = coord_t'(V_TOT - 1);
  localparam coord_t H_ACT_C = coord_t'(H_ACTIVE);
  localparam coord_t V_ACT_C = coord_t'(V_ACTIVE);
  localparam coord_t HS_LO   = coord_t'(HS_BEG);
  localparam coord_t HS_HI   = coord_t'(HS_BEG + H_SYNC);
  localparam coord_t VS_LO   = coord_t'(VS_BEG);
  localparam coord_t VS_HI   = coord_t'(VS_BEG + V_SYNC);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  coord_t           hc_q, hc_d;
  coord_t           vc_q, vc_d;
  logic             frame_start_q, frame_start_d;
  logic             tick, active, h_wrap, v_wrap;
  pix_stage_t       stage_in, stage_out;

  assign tick   = (div_q == DIV_LAST);
  assign h_wrap = (hc_q == H_LAST);
  assign v_wrap = (vc_q == V_LAST);
  assign active = (hc_q < H_ACT_C) && (vc_q < V_ACT_C);

  // vc only moves on the tick where hc wraps, so a frame wrap updates both together.
  always_comb begin
    div_d         = tick ? '0 : div_q + DIV_W'(1);
    hc_d          = hc_q;
    vc_d          = vc_q;
    frame_start_d = tick && h_wrap && v_wrap;
    if (tick) begin
      hc_d = h_wrap ? '0 : hc_q + coord_t'(1);
      if (h_wrap) vc_d = v_wrap ? '0 : vc_q + coord_t'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q         <= '0;
      hc_q          <= '0;
      vc_q          <= '0;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      hc_q          <= hc_d;
      vc_q          <= vc_d;
      frame_start_q <= frame_start_d;
    end
  end

  always_comb begin
    stage_in       = '0;
    stage_in.valid = active;
    stage_in.hs    = in_window(hc_q, HS_LO, HS_HI);
    stage_in.vs    = in_window(vc_q, VS_LO, VS_HI);
    stage_in.rgb   = active ? pixel_in : 12'h000;
  end

  vga_sync_delay #(
    .DEPTH (PIPE_DLY)
  ) u_sync_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (tick),
    .d_i   (stage_in),
    .q_o   (stage_out)
  );

  assign pix_tick    = tick;
  assign h_cnt       = active ? hc_q : '0;
  assign v_cnt       = active ? vc_q : '0;
  assign valid       = stage_out.valid;
  assign vga_r       = stage_out.rgb[11:8];
  assign vga_g       = stage_out.rgb[7:4];
  assign vga_b       = stage_out.rgb[3:0];
  assign hsync       = stage_out.hs ? SYNC_POL : ~SYNC_POL;
  assign vsync       = stage_out.vs ? SYNC_POL : ~SYNC_POL;
  assign frame_start = frame_start_q;

endmodule
